// File: rtl/branch_predict_unit_if.sv
// rtl/branch_predict_unit_if.sv - ID/EX branch predictor bus; BPU_PERF_CNT_EN adds br_cnt_o/miss_cnt_o.
interface branch_predict_unit_if #(
    parameter int PC_W = 32
) ();
    logic            ID_Branch_i;
    logic [PC_W-1:0] ID_pc_i;
    logic            EX_Branch_i;
    logic [PC_W-1:0] EX_pc_i;
    logic            EX_predict_i;
    logic            EX_zero_i;
    logic            ID_predict_o;
    logic            IF_ID_flush_o;
    logic            ID_EX_flush_o;
    logic [1:0]      next_pc_select_o;
`ifdef BPU_PERF_CNT_EN
    logic [31:0]     br_cnt_o;
    logic [31:0]     miss_cnt_o;
`endif

    modport master (
        output ID_Branch_i, ID_pc_i, EX_Branch_i, EX_pc_i, EX_predict_i, EX_zero_i,
        input  ID_predict_o, IF_ID_flush_o, ID_EX_flush_o, next_pc_select_o
`ifdef BPU_PERF_CNT_EN
        , input br_cnt_o, miss_cnt_o
`endif
    );

    modport slave (
        input  ID_Branch_i, ID_pc_i, EX_Branch_i, EX_pc_i, EX_predict_i, EX_zero_i,
        output ID_predict_o, IF_ID_flush_o, ID_EX_flush_o, next_pc_select_o
`ifdef BPU_PERF_CNT_EN
        , output br_cnt_o, miss_cnt_o
`endif
    );
endinterface

// File: rtl/branch_predict_unit.sv
// rtl/branch_predict_unit.sv - Bimodal saturating-counter branch predictor with flush/PC-select steering.
// Optional performance counters are enabled by defining BPU_PERF_CNT_EN.
module branch_predict_unit #(
    parameter int IDX_W = 4,
    parameter int CTR_W = 2,
    parameter int PC_W  = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    branch_predict_unit_if.slave bpu
);
    localparam int                 ENTRIES = 2 ** IDX_W;
    localparam logic [CTR_W-1:0]   CTR_MAX = '1;
    localparam logic [CTR_W-1:0]   CTR_RST = CTR_W'(1) << (CTR_W - 1);

    logic [CTR_W-1:0] r_table [ENTRIES];

    logic [IDX_W-1:0] w_id_idx;
    logic [IDX_W-1:0] w_ex_idx;
    logic [CTR_W-1:0] w_ex_ctr;
    logic [CTR_W-1:0] w_ex_ctr_next;
    logic             w_id_predict;
    logic             w_id_taken;
    logic             w_ex_mis;
    logic             w_unused;

    assign w_id_idx = bpu.ID_pc_i[IDX_W+1:2];
    assign w_ex_idx = bpu.EX_pc_i[IDX_W+1:2];
    assign w_unused = ^{bpu.ID_pc_i[PC_W-1:IDX_W+2], bpu.ID_pc_i[1:0],
                        bpu.EX_pc_i[PC_W-1:IDX_W+2], bpu.EX_pc_i[1:0]};

    // Read is the registered value: a same-cycle EX write to this entry is not bypassed.
    assign w_id_predict = r_table[w_id_idx][CTR_W-1];
    assign w_id_taken   = bpu.ID_Branch_i & w_id_predict;
    assign w_ex_mis     = bpu.EX_Branch_i & (bpu.EX_predict_i ^ bpu.EX_zero_i);

    always_comb begin
        w_ex_ctr      = r_table[w_ex_idx];
        w_ex_ctr_next = w_ex_ctr;
        if (bpu.EX_zero_i) begin
            if (w_ex_ctr != CTR_MAX) begin
                w_ex_ctr_next = w_ex_ctr + CTR_W'(1);
            end
        end else if (w_ex_ctr != '0) begin
            w_ex_ctr_next = w_ex_ctr - CTR_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_table[i] <= CTR_RST;
            end
        end else if (bpu.EX_Branch_i) begin
            r_table[w_ex_idx] <= w_ex_ctr_next;
        end
    end

    // A resolved mispredict in EX squashes both younger stages, whatever ID wants.
    always_comb begin
        bpu.ID_predict_o     = w_id_predict;
        bpu.IF_ID_flush_o    = w_id_taken;
        bpu.ID_EX_flush_o    = 1'b0;
        bpu.next_pc_select_o = w_id_taken ? 2'b01 : 2'b00;
        if (w_ex_mis) begin
            bpu.IF_ID_flush_o    = 1'b1;
            bpu.ID_EX_flush_o    = 1'b1;
            bpu.next_pc_select_o = bpu.EX_predict_i ? 2'b10 : 2'b11;
        end
    end

`ifdef BPU_PERF_CNT_EN
    logic [31:0] r_br_cnt;
    logic [31:0] r_miss_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_br_cnt   <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (bpu.EX_Branch_i && (r_br_cnt != 32'hFFFF_FFFF)) begin
                r_br_cnt <= r_br_cnt + 32'd1;
            end
            if (w_ex_mis && (r_miss_cnt != 32'hFFFF_FFFF)) begin
                r_miss_cnt <= r_miss_cnt + 32'd1;
            end
        end
    end

    assign bpu.br_cnt_o   = r_br_cnt;
    assign bpu.miss_cnt_o = r_miss_cnt;
`endif
endmodule

// File: tb/tb_branch_predict_unit.sv
// tb/tb_branch_predict_unit.sv - Self-checking bench for branch_predict_unit against a table model.
module tb_branch_predict_unit;
    localparam int NENT   = 16;
    localparam int CMAX   = 3;
    localparam int CRESET = 2;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    int   model [NENT];
    longint m_br;
    longint m_miss;

    branch_predict_unit_if #(.PC_W(32)) bus ();

    branch_predict_unit #(.IDX_W(4), .CTR_W(2), .PC_W(32)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bpu   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc / 4) % NENT);
    endfunction

    function automatic logic exp_pred(input logic [31:0] pc);
        return (model[idx_of(pc)] * 2 >= CMAX + 1);
    endfunction

    function automatic logic exp_mis();
        return bus.EX_Branch_i && (bus.EX_predict_i != bus.EX_zero_i);
    endfunction

    function automatic logic [1:0] exp_sel();
        if (exp_mis()) return bus.EX_predict_i ? 2'd2 : 2'd3;
        if (bus.ID_Branch_i && exp_pred(bus.ID_pc_i)) return 2'd1;
        return 2'd0;
    endfunction

    function automatic logic exp_ifid();
        return exp_mis() || (bus.ID_Branch_i && exp_pred(bus.ID_pc_i));
    endfunction

    task automatic drive(input logic id_br, input logic [31:0] id_pc, input logic ex_br,
                         input logic [31:0] ex_pc, input logic ex_pred, input logic ex_zero);
        bus.ID_Branch_i  = id_br;
        bus.ID_pc_i      = id_pc;
        bus.EX_Branch_i  = ex_br;
        bus.EX_pc_i      = ex_pc;
        bus.EX_predict_i = ex_pred;
        bus.EX_zero_i    = ex_zero;
        #1;
    endtask

    task automatic tick();
        logic   was_rst;
        logic   br;
        logic   mis;
        logic   tk;
        int     ix;
        was_rst = rst;
        br      = bus.EX_Branch_i;
        mis     = exp_mis();
        tk      = bus.EX_zero_i;
        ix      = idx_of(bus.EX_pc_i);
        @(posedge clk);
        #1;
        if (was_rst) begin
            for (int i = 0; i < NENT; i++) model[i] = CRESET;
            m_br   = 0;
            m_miss = 0;
        end else begin
            if (br) begin
                if (tk) model[ix] = (model[ix] < CMAX) ? model[ix] + 1 : CMAX;
                else    model[ix] = (model[ix] > 0) ? model[ix] - 1 : 0;
                if (m_br < 64'hFFFF_FFFF) m_br++;
            end
            if (mis && m_miss < 64'hFFFF_FFFF) m_miss++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 32'h10, 1'b1, 32'h10, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        drive(1'b1, 32'h00, 1'b0, 32'h0, 1'b0, 1'b0);
        n_cmp++;
        if (bus.ID_predict_o !== 1'b1) begin
            n_err++; $display("FAIL reset_pred: got %b want 1", bus.ID_predict_o);
        end
        n_cmp++;
        if (bus.IF_ID_flush_o !== 1'b1 || bus.ID_EX_flush_o !== 1'b0) begin
            n_err++; $display("FAIL reset_flush: got %b%b want 10", bus.IF_ID_flush_o, bus.ID_EX_flush_o);
        end
        n_cmp++;
        if (bus.next_pc_select_o !== 2'b01) begin
            n_err++; $display("FAIL reset_sel: got %b want 01", bus.next_pc_select_o);
        end
        drive(1'b1, 32'h10, 1'b0, 32'h0, 1'b0, 1'b0);
        n_cmp++;
        if (bus.ID_predict_o !== 1'b1) begin
            n_err++; $display("FAIL reset_discard_update: got %b want 1", bus.ID_predict_o);
        end
        drive(1'b0, 32'h00, 1'b0, 32'h0, 1'b0, 1'b0);
        n_cmp++;
        if (bus.IF_ID_flush_o !== 1'b0 || bus.next_pc_select_o !== 2'b00) begin
            n_err++; $display("FAIL reset_nobranch: got %b/%b want 0/00", bus.IF_ID_flush_o, bus.next_pc_select_o);
        end
    endtask

    task automatic test_training();
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, 32'h10, 1'b1, 32'h10, 1'b1, 1'b0);
            tick();
        end
        drive(1'b1, 32'h10, 1'b0, 32'h0, 1'b0, 1'b0);
        n_cmp++;
        if (bus.ID_predict_o !== 1'b0 || model[4] != 0) begin
            n_err++; $display("FAIL train_pred: got %b want 0 (model %0d)", bus.ID_predict_o, model[4]);
        end
        n_cmp++;
        if (bus.next_pc_select_o !== 2'b00 || bus.IF_ID_flush_o !== 1'b0) begin
            n_err++; $display("FAIL train_sel: got %b/%b want 00/0", bus.next_pc_select_o, bus.IF_ID_flush_o);
        end
        drive(1'b0, 32'h10, 1'b1, 32'h10, 1'b1, 1'b0);
        tick();
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, 32'h10, 1'b1, 32'h10, 1'b0, 1'b1);
            tick();
        end
        drive(1'b1, 32'h10, 1'b0, 32'h0, 1'b0, 1'b0);
        n_cmp++;
        if (bus.ID_predict_o !== 1'b1) begin
            n_err++; $display("FAIL train_floor: got %b want 1", bus.ID_predict_o);
        end
    endtask

    task automatic test_mispredict();
        drive(1'b1, 32'h00, 1'b1, 32'h04, 1'b1, 1'b0);
        n_cmp++;
        if (bus.IF_ID_flush_o !== 1'b1 || bus.ID_EX_flush_o !== 1'b1 || bus.next_pc_select_o !== 2'b10) begin
            n_err++; $display("FAIL mis_taken: got %b%b/%b want 11/10",
                              bus.IF_ID_flush_o, bus.ID_EX_flush_o, bus.next_pc_select_o);
        end
        drive(1'b1, 32'h00, 1'b1, 32'h04, 1'b0, 1'b1);
        n_cmp++;
        if (bus.IF_ID_flush_o !== 1'b1 || bus.ID_EX_flush_o !== 1'b1 || bus.next_pc_select_o !== 2'b11) begin
            n_err++; $display("FAIL mis_nottaken: got %b%b/%b want 11/11",
                              bus.IF_ID_flush_o, bus.ID_EX_flush_o, bus.next_pc_select_o);
        end
        drive(1'b1, 32'h00, 1'b1, 32'h04, 1'b1, 1'b1);
        n_cmp++;
        if (bus.ID_EX_flush_o !== 1'b0 || bus.next_pc_select_o !== 2'b01) begin
            n_err++; $display("FAIL mis_correct: got %b/%b want 0/01", bus.ID_EX_flush_o, bus.next_pc_select_o);
        end
        drive(1'b0, 32'h00, 1'b0, 32'h04, 1'b0, 1'b0);
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 32'h20, 1'b1, 32'h20, 1'b1, 1'b1);
            tick();
        end
        drive(1'b0, 32'h20, 1'b1, 32'h20, 1'b1, 1'b0);
        tick();
        drive(1'b1, 32'h20, 1'b0, 32'h0, 1'b0, 1'b0);
        n_cmp++;
        if (bus.ID_predict_o !== 1'b1 || model[8] != 2) begin
            n_err++; $display("FAIL sat_ceiling: got %b want 1 (model %0d)", bus.ID_predict_o, model[8]);
        end
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 32'h24, 1'b1, 32'h24, 1'b1, 1'b1);
            tick();
        end
        drive(1'b0, 32'h24, 1'b1, 32'h24, 1'b1, 1'b0);
        tick();
        drive(1'b1, 32'h24, 1'b0, 32'h0, 1'b0, 1'b0);
        n_cmp++;
        if (bus.ID_predict_o !== 1'b1) begin
            n_err++; $display("FAIL sat_hold: got %b want 1", bus.ID_predict_o);
        end
    endtask

    task automatic test_same_index();
        drive(1'b1, 32'h30, 1'b1, 32'h30, 1'b1, 1'b0);
        n_cmp++;
        if (bus.ID_predict_o !== 1'b1) begin
            n_err++; $display("FAIL same_idx_pre: got %b want 1", bus.ID_predict_o);
        end
        tick();
        n_cmp++;
        if (bus.ID_predict_o !== 1'b0) begin
            n_err++; $display("FAIL same_idx_post1: got %b want 0", bus.ID_predict_o);
        end
        tick();
        n_cmp++;
        if (bus.ID_predict_o !== 1'b0 || model[12] != 0) begin
            n_err++; $display("FAIL same_idx_post2: got %b want 0 (model %0d)", bus.ID_predict_o, model[12]);
        end
        drive(1'b0, 32'h30, 1'b0, 32'h30, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 59) == 0);
            drive(1'(($urandom_range(0, 3)) != 0), $urandom, 1'($urandom_range(0, 2) != 0),
                  $urandom, 1'($urandom), 1'($urandom));
            n_cmp++;
            if (bus.ID_predict_o !== exp_pred(bus.ID_pc_i)) begin
                n_err++; $display("FAIL rand_pred c=%0d: got %b want %b", c, bus.ID_predict_o, exp_pred(bus.ID_pc_i));
            end
            n_cmp++;
            if (bus.IF_ID_flush_o !== exp_ifid() || bus.ID_EX_flush_o !== exp_mis()) begin
                n_err++; $display("FAIL rand_flush c=%0d: got %b%b want %b%b", c,
                                  bus.IF_ID_flush_o, bus.ID_EX_flush_o, exp_ifid(), exp_mis());
            end
            n_cmp++;
            if (bus.next_pc_select_o !== exp_sel()) begin
                n_err++; $display("FAIL rand_sel c=%0d: got %b want %b", c, bus.next_pc_select_o, exp_sel());
            end
            tick();
`ifdef BPU_PERF_CNT_EN
            n_cmp++;
            if (bus.br_cnt_o !== m_br[31:0] || bus.miss_cnt_o !== m_miss[31:0]) begin
                n_err++; $display("FAIL rand_perf c=%0d: got %0d/%0d want %0d/%0d", c,
                                  bus.br_cnt_o, bus.miss_cnt_o, m_br, m_miss);
            end
`endif
        end
        rst = 1'b0;
    endtask

`ifdef BPU_PERF_CNT_EN
    task automatic test_perf();
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        drive(1'b0, 32'h0, 1'b1, 32'h40, 1'b1, 1'b1);
        tick();
        drive(1'b0, 32'h0, 1'b1, 32'h44, 1'b1, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 32'h48, 1'b1, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b1, 32'h48, 1'b0, 1'b0);
        tick();
        n_cmp++;
        if (bus.br_cnt_o !== 32'd3 || bus.miss_cnt_o !== 32'd1) begin
            n_err++; $display("FAIL perf_count: got %0d/%0d want 3/1", bus.br_cnt_o, bus.miss_cnt_o);
        end
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b1, 32'h40, 1'b1, 1'b0);
        tick();
        rst = 1'b0;
        n_cmp++;
        if (bus.br_cnt_o !== 32'd0 || bus.miss_cnt_o !== 32'd0) begin
            n_err++; $display("FAIL perf_reset: got %0d/%0d want 0/0", bus.br_cnt_o, bus.miss_cnt_o);
        end
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask
`endif

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        m_br   = 0;
        m_miss = 0;
        for (int i = 0; i < NENT; i++) model[i] = CRESET;
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        test_reset();
        test_training();
        test_mispredict();
        test_saturation();
        test_same_index();
        test_random();
`ifdef BPU_PERF_CNT_EN
        test_perf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/branch_predict_unit.md
BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 The parameter IDX_W SHALL default to 4 and set the pattern-table index width, giving 2^IDX_W entries.
REQ-002 The parameter CTR_W SHALL default to 2 and set the saturating-counter width per entry, with a legal range of 1..4.
REQ-003 The parameter PC_W SHALL default to 32 and set the PC width.
REQ-004 clk_i  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_i  input  1  synchronous, active-high reset.
REQ-006 ID_Branch_i  input  1  the instruction in ID is a conditional branch.
REQ-007 ID_pc_i  input  PC_W  PC of the instruction in ID.
REQ-008 EX_Branch_i  input  1  the instruction in EX is a conditional branch.
REQ-009 EX_pc_i  input  PC_W  PC of the branch in EX.
REQ-010 EX_predict_i  input  1  prediction carried down the pipe with the EX branch.
REQ-011 EX_zero_i  input  1  actual outcome in EX (1 = taken).
REQ-012 ID_predict_o  output  1  prediction for the ID branch (1 = taken).
REQ-013 IF_ID_flush_o  output  1  flush the IF/ID register.
REQ-014 ID_EX_flush_o  output  1  flush the ID/EX register.
REQ-015 next_pc_select_o  output  2  PC source: 00 = PC+4, 01 = ID branch target, 10 = EX fall-through PC, 11 = EX branch target.

Function
REQ-016 The block SHALL hold 2^IDX_W counters of CTR_W bits, indexed by pc[IDX_W+1:2].
REQ-017 ID_predict_o SHALL equal the MSB of entry[ID_pc_i index], combinationally, independent of ID_Branch_i.
REQ-018 Define ID_taken = ID_Branch_i & ID_predict_o and EX_mis = EX_Branch_i & (EX_predict_i ^ EX_zero_i).
REQ-019 When EX_mis=0, the outputs SHALL be: IF_ID_flush_o = ID_taken; ID_EX_flush_o = 0; next_pc_select_o = ID_taken ? 01 : 00.
REQ-020 When EX_mis=1, it SHALL override regardless of ID state: both flushes = 1; next_pc_select_o = EX_predict_i ? 10 : 11.
REQ-021 The flush and select outputs SHALL be combinational, with zero latency from their inputs.
REQ-022 When EX_Branch_i=1, entry[EX_pc_i index] SHALL update on the next clock edge: increment if EX_zero_i=1, else decrement.
REQ-023 Counters SHALL saturate: an increment at 2^CTR_W-1 and a decrement at 0 SHALL leave the value unchanged.
REQ-024 The table SHALL update regardless of whether the prediction was correct.
REQ-025 When EX_Branch_i=0, the table SHALL be unchanged.
REQ-026 If the ID and EX indices are equal in the same cycle, ID_predict_o SHALL use the pre-update value; there is no bypass.
REQ-027 Aliasing between PCs sharing an index is permitted and not detected.
REQ-028 Only one table write per cycle SHALL occur; read-after-write ordering is a single clock edge.

Reset
REQ-029 When rst_i=1 at a clock edge, every entry SHALL be set to 2^(CTR_W-1), i.e. weakly taken.
REQ-030 When rst_i=1, any pending EX update in that cycle SHALL be discarded.
REQ-031 During and after reset, the outputs SHALL follow REQ-017..REQ-020 from the reset table contents; they have no state of their own.
REQ-032 When CTR_W=1, the reset value SHALL be 1, i.e. taken.

Configuration
REQ-033 The macro BPU_PERF_CNT_EN SHALL enable two 32-bit output ports: br_cnt_o (EX branches resolved) and miss_cnt_o (EX_mis events).
REQ-034 With BPU_PERF_CNT_EN, both counters SHALL reset to 0, increment on the clock edge per qualifying cycle, and saturate at 32'hFFFFFFFF.
REQ-035 Without BPU_PERF_CNT_EN, the ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-036 Reset test: after rst_i, ID_pc_i=0x00 with ID_Branch_i=1 -> ID_predict_o=1, IF_ID_flush_o=1, next_pc_select_o=01.
REQ-037 Training test: two EX not-taken updates at PC 0x10 (EX_zero_i=0) -> entry drops 2->1->0, and ID_predict_o=0 at PC 0x10 -> next_pc_select_o=00.
REQ-038 Mispredict test: EX_Branch_i=1, EX_predict_i=1, EX_zero_i=0, ID_Branch_i=1 predicted taken -> both flushes=1 and next_pc_select_o=10; with EX_predict_i=0, EX_zero_i=1 -> 11.
REQ-039 Saturation test: five taken updates at PC 0x20 -> counter holds 3; one not-taken update -> 2, and the prediction stays 1.
REQ-040 Same-index test: ID_pc_i=EX_pc_i=0x30 (entry=2) with a not-taken update -> ID_predict_o=1 in that cycle and 0 in the next cycle after a second not-taken update.
REQ-041 Performance-counter test (BPU_PERF_CNT_EN): 3 resolved branches including 1 mispredict -> br_cnt_o=3 and miss_cnt_o=1; rst_i mid-run -> both read 0.
